// File: rtl/sram_port_arbiter.sv
// Round-robin arbiter sharing one 8-bit SRAM macro between word-wide requesters.
// Each 32-bit access is sequenced as four byte beats on the macro pins.
module sram_port_arbiter #(
  parameter int NUM_REQ    = 2,
  parameter int ADDR_WIDTH = 9
) (
  input  logic                              ACLK,
  input  logic                              ARESETN,
  input  logic [NUM_REQ-1:0]                req_valid,
  output logic [NUM_REQ-1:0]                req_ready,
  input  logic [NUM_REQ-1:0]                req_we,
  input  logic [NUM_REQ*(ADDR_WIDTH-2)-1:0] req_addr,
  input  logic [NUM_REQ*32-1:0]             req_wdata,
  input  logic [NUM_REQ*4-1:0]              req_wstrb,
  output logic [NUM_REQ-1:0]                rsp_valid,
  input  logic [NUM_REQ-1:0]                rsp_ready,
  output logic [31:0]                       rsp_rdata,
  output logic                              sram_cen_n,
  output logic                              sram_gwen_n,
  output logic [ADDR_WIDTH-1:0]             sram_a,
  output logic [7:0]                        sram_d,
  input  logic [7:0]                        sram_q
);

  localparam int WAW = ADDR_WIDTH - 2;
  localparam int IW  = $clog2(NUM_REQ);

  typedef enum logic [1:0] {
    IDLE,
    ISSUE,
    WAIT,
    RESP
  } state_t;

  state_t state, state_nx;

  logic [IW-1:0]         rr;
  logic [IW-1:0]         id;
  logic [IW-1:0]         pick;
  logic                  found;
  logic                  we_q;
  logic [WAW-1:0]        addr_q;
  logic [31:0]           wdata_q;
  logic [3:0]            wstrb_q;
  logic [1:0]            beat;
  logic [31:0]           rdata;
  logic [ADDR_WIDTH-1:0] a_q;
  logic [7:0]            d_q;

  // first valid requester after the last grant
  always_comb begin
    int j;
    pick  = '0;
    found = 1'b0;
    j     = 0;
    for (int k = 1; k <= NUM_REQ; k++) begin
      j = int'(rr) + k;
      if (j >= NUM_REQ) j = j - NUM_REQ;
      if (!found && req_valid[j]) begin
        found = 1'b1;
        pick  = IW'(j);
      end
    end
  end

  always_comb begin
    req_ready = '0;
    if (state == IDLE && found) req_ready[pick] = 1'b1;
  end

  always_comb begin
    rsp_valid = '0;
    if (state == RESP) rsp_valid[id] = 1'b1;
  end

  assign rsp_rdata = rdata;

  always_comb begin
    state_nx = state;
    unique case (state)
      IDLE:  if (found) state_nx = ISSUE;
      ISSUE: if (beat == 2'd3) state_nx = we_q ? RESP : WAIT;
      WAIT:  state_nx = RESP;
      RESP:  if (rsp_ready[id]) state_nx = IDLE;
      default: state_nx = IDLE;
    endcase
  end

  // macro pins: driven live during ISSUE, a/d hold otherwise
  always_comb begin
    sram_cen_n  = 1'b1;
    sram_gwen_n = 1'b1;
    sram_a      = a_q;
    sram_d      = d_q;
    if (state == ISSUE) begin
      sram_a      = {addr_q, beat};
      sram_gwen_n = ~we_q;
      sram_cen_n  = we_q ? ~wstrb_q[beat] : 1'b0;
      if (we_q) sram_d = wdata_q[{beat, 3'b000} +: 8];
    end
  end

  always_ff @(posedge ACLK or negedge ARESETN) begin
    if (!ARESETN) begin
      state   <= IDLE;
      rr      <= IW'(NUM_REQ - 1);
      id      <= '0;
      we_q    <= 1'b0;
      addr_q  <= '0;
      wdata_q <= '0;
      wstrb_q <= '0;
      beat    <= '0;
      rdata   <= '0;
      a_q     <= '0;
      d_q     <= '0;
    end else begin
      state <= state_nx;
      unique case (state)
        IDLE: begin
          if (found) begin
            id      <= pick;
            rr      <= pick;
            we_q    <= req_we[pick];
            addr_q  <= req_addr[int'(pick)*WAW +: WAW];
            wdata_q <= req_wdata[int'(pick)*32 +: 32];
            wstrb_q <= req_wstrb[int'(pick)*4 +: 4];
            beat    <= '0;
            rdata   <= '0;
          end
        end
        ISSUE: begin
          beat <= beat + 2'd1;
          a_q  <= sram_a;
          d_q  <= sram_d;
          // byte of the previous beat arrives now
          if (!we_q && beat != 2'd0)
            rdata[{beat - 2'd1, 3'b000} +: 8] <= sram_q;
        end
        WAIT: rdata[31:24] <= sram_q;
        default: ;
      endcase
    end
  end

endmodule
